// File: rtl/gf_div_arbiter.sv
// Round-robin arbiter sharing one GF(2^8) divider (poly 0x15F) among NUM_REQ requesters,
// followed by a freezable result pipeline carrying requester tag and divide-by-zero flag.
module gf_div_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int PIPE_STAGES = 2,
  parameter int ID_W        = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*8-1:0] req_num,
  input  logic [NUM_REQ*8-1:0] req_den,
  input  logic                 hold,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_quot,
  output logic                 rsp_div0,
  output logic                 busy,
  output logic [15:0]          div0_cnt
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h5F : 8'h00);
    end
    return r;
  endfunction

  // a^-1 = a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  logic [7:0] num_a [NUM_REQ];
  logic [7:0] den_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpk
    assign num_a[g] = req_num[8*g +: 8];
    assign den_a[g] = req_den[8*g +: 8];
  end

  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] gnt_idx;
  logic            found;
  logic [ID_W:0]   sum;
  logic            xfer;
  logic [7:0]      num_sel, den_sel, quot_c;
  logic            div0_c;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
      if (!found && req_valid[sum[ID_W-1:0]]) begin
        found   = 1'b1;
        gnt_idx = sum[ID_W-1:0];
      end
    end
  end

  assign xfer      = found && !hold;
  assign req_ready = xfer ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign rr_ptr_d  = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;

  assign num_sel = num_a[gnt_idx];
  assign den_sel = den_a[gnt_idx];
  assign div0_c  = (den_sel == 8'h00);
  assign quot_c  = div0_c ? 8'h00 : gf_mul(num_sel, gf_inv(den_sel));

  logic [PIPE_STAGES-1:0]            vld_pipe_q;
  logic [PIPE_STAGES-1:0][ID_W-1:0]  id_pipe_q;
  logic [PIPE_STAGES-1:0][7:0]       quot_pipe_q;
  logic [PIPE_STAGES-1:0]            div0_pipe_q;
  logic [15:0]                       div0_cnt_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_pipe_q  <= '0;
      id_pipe_q   <= '0;
      quot_pipe_q <= '0;
      div0_pipe_q <= '0;
      rr_ptr_q    <= '0;
      div0_cnt_q  <= '0;
    end else if (!hold) begin
      // Stage 0 captures every cycle; its payload only matters when valid.
      vld_pipe_q[0]  <= xfer;
      id_pipe_q[0]   <= gnt_idx;
      quot_pipe_q[0] <= quot_c;
      div0_pipe_q[0] <= div0_c;
      for (int k = 1; k < PIPE_STAGES; k++) begin
        vld_pipe_q[k]  <= vld_pipe_q[k-1];
        id_pipe_q[k]   <= id_pipe_q[k-1];
        quot_pipe_q[k] <= quot_pipe_q[k-1];
        div0_pipe_q[k] <= div0_pipe_q[k-1];
      end
      if (xfer) rr_ptr_q <= rr_ptr_d;
      if (xfer && div0_c && div0_cnt_q != 16'hFFFF) div0_cnt_q <= div0_cnt_q + 16'd1;
    end
  end

  assign rsp_valid = vld_pipe_q[PIPE_STAGES-1];
  assign rsp_id    = id_pipe_q[PIPE_STAGES-1];
  assign rsp_quot  = quot_pipe_q[PIPE_STAGES-1];
  assign rsp_div0  = div0_pipe_q[PIPE_STAGES-1];
  assign busy      = |vld_pipe_q;
  assign div0_cnt  = div0_cnt_q;

endmodule
